// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
//
// Purpose: shared definitions for the EX-stage divide sequencer and the EX
// ALU decoder. It holds the RV32M divide operation encodings, the sequencer
// state constants and the ALU opcodes. The sequencer can only use ALU
// operations that the ALU decoder also understands.
//
// Contents:
//   XLEN                      operand/result width (also the iteration count)
//   div_op_e                  DIV / DIVU / REM / REMU encodings
//   state_t + S_* constants   sequencer states
//   ALU_ADD/ALU_SUB/ALU_SLTU  ALU opcodes
//   op_is_signed/op_is_rem    helpers for decoding div_op
// ---------------------------------------------------------------------------
package div_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // The states are plain constants so that older tools and the
    // surrounding pipeline code can compare against them directly.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_NEG_A = 3'd1;
    localparam state_t S_NEG_B = 3'd2;
    localparam state_t S_CMP   = 3'd3;
    localparam state_t S_SUB   = 3'd4;
    localparam state_t S_FIX   = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // DIV and REM are the signed operations. Bit 0 of the encoding is clear
    // for both of them.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//
// Purpose: multi-cycle RV32M divide/remainder sequencer. It borrows the single
// EX-stage ALU instead of using a dedicated divider. When idle it forwards the
// pipeline's ALU operands. While a divide runs it owns the ALU and performs a
// restoring division with SUB and SLTU only. It stalls the pipeline until a
// one-cycle div_done pulse arrives.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_a, ex_b               pipeline ALU operands (forwarded while free)
//   ex_alu_control           pipeline ALU opcode (forwarded while free)
//   div_start                divide request, honoured in IDLE/DONE only
//   div_op                   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_a, div_b             dividend and divisor, captured with div_start
//   div_flush                abort the divide in flight
//   alu_a, alu_b             operands driven to the shared ALU
//   alu_control              opcode driven to the shared ALU
//   alu_result               combinational result from the shared ALU
//   div_busy                 stall request while the ALU is borrowed
//   div_done                 one-cycle completion pulse
//   div_result               quotient or remainder, valid with div_done
//
// Build option: DIV_SEQ_SPECIAL_EN. When this macro is defined, a divide by
// zero or a signed 0x80000000 / -1 skips the loop. Such a request goes from
// accept straight to DONE. The results are the same in both builds.
// ---------------------------------------------------------------------------
import div_seq_pkg::*;

module div_seq (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [3:0]      ex_alu_control,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_a,
    input  logic [XLEN-1:0] div_b,
    input  logic            div_flush,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    localparam int CW = $clog2(XLEN);

    state_t          state;
    div_op_e         op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] d_reg;
    logic [XLEN-1:0] r_reg;
    logic [XLEN-1:0] q_reg;
    logic [CW-1:0]   count;
    logic            lt_reg;
    logic            a_sign;
    logic            b_sign;

    logic [XLEN-1:0] r_shift;
    logic            r_carry;
    logic [XLEN-1:0] fix_value;
    logic            fix_negate;
    logic            start_ok;

    // The next partial remainder is the current one shifted left, with the
    // top quotient bit shifted in. The bit that falls off the top is kept as
    // r_carry. When it is set, the true 33-bit remainder is at least D, so
    // the subtraction must happen whatever SLTU reported.
    always_comb begin
        r_shift    = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
        r_carry    = r_reg[XLEN-1];
        fix_value  = op_is_rem(op_reg) ? r_reg : q_reg;
        fix_negate = 1'b0;
        case (op_reg)
            OP_DIV:  fix_negate = (a_sign ^ b_sign) && (d_reg != '0);
            OP_REM:  fix_negate = a_sign;
            default: fix_negate = 1'b0;
        endcase
    end

    // A new request is taken only when the ALU is free. A flush in the same
    // cycle wins over the request.
    assign start_ok = div_start && !div_flush
                      && ((state == S_IDLE) || (state == S_DONE));

`ifdef DIV_SEQ_SPECIAL_EN
    logic            special_hit;
    logic [XLEN-1:0] special_value;

    // Fast path for the cases whose answer does not depend on the loop.
    // These values match what the full loop and FIX would produce.
    always_comb begin
        special_hit   = 1'b0;
        special_value = '0;
        if (div_b == '0) begin
            special_hit   = 1'b1;
            special_value = op_is_rem(div_op) ? div_a : '1;
        end else if (op_is_signed(div_op) && (div_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (div_b == '1)) begin
            special_hit   = 1'b1;
            special_value = op_is_rem(div_op) ? '0 : div_a;
        end
    end
`endif

    // ALU ownership mux. In IDLE and DONE the pipeline has the ALU. In every
    // other state the sequencer drives the operation that the state needs.
    // There is no register here, so alu_result comes back in the same cycle.
    always_comb begin
        alu_a       = ex_a;
        alu_b       = ex_b;
        alu_control = ex_alu_control;
        case (state)
            S_NEG_A: begin
                alu_a       = '0;
                alu_b       = a_reg;
                alu_control = ALU_SUB;
            end
            S_NEG_B: begin
                alu_a       = '0;
                alu_b       = d_reg;
                alu_control = ALU_SUB;
            end
            S_CMP: begin
                alu_a       = r_shift;
                alu_b       = d_reg;
                alu_control = ALU_SLTU;
            end
            S_SUB: begin
                alu_a       = r_shift;
                alu_b       = d_reg;
                alu_control = ALU_SUB;
            end
            S_FIX: begin
                alu_a       = '0;
                alu_b       = fix_value;
                alu_control = ALU_SUB;
            end
            default: begin
                alu_a       = ex_a;
                alu_b       = ex_b;
                alu_control = ex_alu_control;
            end
        endcase
    end

    assign div_busy = (state != S_IDLE) && (state != S_DONE);
    assign div_done = (state == S_DONE);

    // Sequencer. NEG_A and NEG_B always take one cycle each, even when
    // nothing is negated, so the latency is the same for every operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_reg     <= OP_DIV;
            a_reg      <= '0;
            d_reg      <= '0;
            r_reg      <= '0;
            q_reg      <= '0;
            count      <= '0;
            lt_reg     <= 1'b0;
            a_sign     <= 1'b0;
            b_sign     <= 1'b0;
            div_result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start_ok) begin
                        op_reg <= div_op_e'(div_op);
                        a_reg  <= div_a;
                        d_reg  <= div_b;
                        a_sign <= div_a[XLEN-1];
                        b_sign <= div_b[XLEN-1];
`ifdef DIV_SEQ_SPECIAL_EN
                        if (special_hit) begin
                            div_result <= special_value;
                            state      <= S_DONE;
                        end else begin
                            state <= S_NEG_A;
                        end
`else
                        state <= S_NEG_A;
`endif
                    end
                end
                S_NEG_A: begin
                    if (div_flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (op_is_signed(op_reg) && a_reg[XLEN-1]) begin
                            a_reg <= alu_result;
                        end
                        state <= S_NEG_B;
                    end
                end
                S_NEG_B: begin
                    if (div_flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (op_is_signed(op_reg) && d_reg[XLEN-1]) begin
                            d_reg <= alu_result;
                        end
                        r_reg <= '0;
                        q_reg <= a_reg;
                        count <= '0;
                        state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (div_flush) begin
                        state <= S_IDLE;
                    end else begin
                        lt_reg <= alu_result[0];
                        state  <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (div_flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (r_carry || !lt_reg) begin
                            r_reg <= alu_result;
                            q_reg <= {q_reg[XLEN-2:0], 1'b1};
                        end else begin
                            r_reg <= r_shift;
                            q_reg <= {q_reg[XLEN-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        state <= (count == CW'(XLEN - 1)) ? S_FIX : S_CMP;
                    end
                end
                S_FIX: begin
                    if (div_flush) begin
                        state <= S_IDLE;
                    end else begin
                        div_result <= fix_negate ? alu_result : fix_value;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle RV32M divide/remainder sequencer in the EX stage that time-shares the single EX ALU instead of adding a dedicated divider. While idle it passes the pipeline's ALU operands straight through. On a divide request it takes ownership of the ALU and runs a restoring division using only ALU SUB and SLTU operations. It stalls the pipeline until a one-cycle completion pulse delivers the quotient or remainder.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_a, ex_b  in  XLEN  pipeline ALU operands, forwarded while the ALU is free.
- ex_alu_control  in  4  pipeline ALU opcode, forwarded while the ALU is free.
- div_start  in  1  divide request; sampled only in IDLE or DONE.
- div_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- div_a, div_b  in  XLEN  dividend and divisor; captured with div_start.
- div_flush  in  1  abort the current divide (pipeline flush).
- alu_a, alu_b  out  XLEN  operands driven to the shared ALU.
- alu_control  out  4  opcode driven to the ALU: ADD 0000, SUB 0001, SLTU 1001.
- alu_result  in  XLEN  ALU result, purely combinational from alu_a/alu_b/alu_control.
- div_busy  out  1  stall request; high whenever the sequencer owns the ALU.
- div_done  out  1  one-cycle completion pulse.
- div_result  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); valid while div_done is high.

## Operation
- States: IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE.
- IDLE and DONE:
  - ALU mux passes ex_a, ex_b and ex_alu_control through; div_busy = 0.
  - div_start captures op, a and b, then goes to NEG_A.
- NEG_A: ALU SUB(0, a).
  - Signed op with negative a: A = result; otherwise A unchanged.
  - Always spends one cycle, so latency is fixed.
- NEG_B: same as NEG_A for the divisor, giving D. Then R = 0, Q = A, count = 0.
- Loop, XLEN iterations of CMP followed by SUB:
  - R' = {R[XLEN-2:0], Q[XLEN-1]}; c = R[XLEN-1] (the shifted-out bit).
  - CMP: ALU SLTU(R', D); register lt.
  - SUB: ALU SUB(R', D).
    - If c or !lt: R = result and Q = {Q[XLEN-2:0], 1}.
    - Otherwise: R = R' and Q = {Q[XLEN-2:0], 0}.
    - count increments; after the last iteration go to FIX, else back to CMP.
- FIX: ALU SUB(0, X), where X = Q for DIV/DIVU and X = R for REM/REMU.
  - DIV: negate when operand signs differ and b != 0.
  - REM: negate when dividend a is negative.
  - Unsigned ops: never negate.
  - The selected value is registered into div_result.
- DONE: div_done = 1 for exactly one cycle; then IDLE, or NEG_A if div_start is accepted.
- Required corner results:
  - x/0: DIVU and DIV give all-ones; REM and REMU give x.
  - DIV 0x80000000 / -1 gives 0x80000000; REM of the same operands gives 0.
  - These results fall out of the loop plus the FIX rules above.
- div_flush in any state other than IDLE: go to IDLE next cycle, no div_done, div_result unchanged.
- div_flush takes priority over div_start in the same cycle.
- div_start outside IDLE/DONE is ignored.

## Timing
- Reset: state IDLE; R, Q, A, D, count and div_result = 0; div_busy = 0; div_done = 0.
- Reset overrides everything, including mid-operation; ALU outputs revert to passthrough.
- Accept edge = cycle 0. NEG_A is cycle 1, NEG_B cycle 2, the loop cycles 3..66, FIX cycle 67.
- DONE is cycle 68: div_done and div_result are valid in cycle 68.
- div_busy is high in cycles 1..67.
- Back-to-back: a start accepted in DONE puts the next NEG_A in cycle 69.
- ALU outputs are combinational from state and registers; there is no extra pipeline register.

## Configuration
- DIV_SEQ_SPECIAL_EN defined:
  - Divisor zero, or DIV/REM with 0x80000000 / -1, goes from accept straight to DONE.
  - div_done arrives in cycle 1 and div_busy never asserts.
- DIV_SEQ_SPECIAL_EN undefined:
  - All requests take the fixed 68-cycle path.
  - Results are bit-identical in both builds.

## Structure
- Shared package div_seq_pkg holds:
  - the div_op encodings;
  - the state enum;
  - the ALU opcode constants ALU_ADD, ALU_SUB, ALU_SLTU, which the ALU decoder also uses.
- No sub-module: the ALU stays external in the EX stage so one instance is shared. The counter and mux stay inline.

## Test plan
- Idle passthrough: ex_a=5, ex_b=3, ex_alu_control=0000 -> alu_a=5, alu_b=3, alu_control=0000, div_busy=0.
- DIVU 100/7 -> div_busy high cycles 1..67, div_done in cycle 68, div_result=14; REMU of the same operands -> 2.
- Signed: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD.
- Corners:
  - DIVU 1234/0 -> 0xFFFFFFFF.
  - REM -5/0 -> 0xFFFFFFFB.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - Each completes in cycle 68, or in cycle 1 with DIV_SEQ_SPECIAL_EN.
- Flush in cycle 30 -> IDLE in cycle 31, no div_done; a new start in cycle 31 completes normally.
- Reset asserted in cycle 40 -> every output at its reset value the next cycle; a start pulse during DONE is accepted back-to-back.
